// File: rtl/mips_mem_pkg.sv
// Shared encodings for the store datapath: access sizes, FSM states and the dmem write payload.
package mips_mem_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WEN_W  = DATA_W / 8;

    localparam logic [1:0] SIZE_B   = 2'b00;
    localparam logic [1:0] SIZE_H   = 2'b01;
    localparam logic [1:0] SIZE_W   = 2'b10;
    localparam logic [1:0] SIZE_RSV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [WEN_W-1:0]  wen;
    } store_pkt_t;

endpackage

// File: rtl/store_lane_pack.sv
// Combinational store narrowing: lane replication, byte enables and alignment check.
// STORE_ADES_EXC_EN enables the misalign flag; otherwise it is constant 0.
module store_lane_pack
    import mips_mem_pkg::*;
(
    input  logic [1:0]        size,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] data,
    output logic [WEN_W-1:0]  wen_c,
    output logic [DATA_W-1:0] wdata_c,
    output logic              misalign_c
);

    always_comb begin
        wen_c      = 4'b1111;
        wdata_c    = data;
        misalign_c = 1'b0;
        case (size)
            SIZE_B: begin
                wdata_c = {4{data[7:0]}};
                wen_c   = 4'b0001 << addr_lo;
            end
            SIZE_H: begin
                wdata_c = {2{data[15:0]}};
                wen_c   = addr_lo[1] ? 4'b1100 : 4'b0011;
`ifdef STORE_ADES_EXC_EN
                misalign_c = addr_lo[0];
`endif
            end
            default: begin
                // Word and the reserved encoding both store the full word
                wdata_c = data;
                wen_c   = 4'b1111;
`ifdef STORE_ADES_EXC_EN
                misalign_c = (size == SIZE_RSV) || (addr_lo != 2'b00);
`endif
            end
        endcase
    end

endmodule

// File: rtl/mem_store_pack.sv
// Store unit: packs GPR data into byte lanes and runs one outstanding dmem write with ack/timeout.
// Optional STORE_ADES_EXC_EN raises exc_ades/bad_vaddr on misaligned stores instead of writing.
module mem_store_pack
    import mips_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_size,
    output logic              mem_en,
    output logic [WEN_W-1:0]  mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    output logic              done,
    output logic              bus_err,
    output logic              exc_ades,
    output logic [ADDR_W-1:0] bad_vaddr
);

    localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam int unsigned CNT_W   = (TO_LAST < 1) ? 1 : $clog2(TO_LAST + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    store_pkt_t        pkt_q, pkt_d;
    logic              en_q, en_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ades_q, ades_d;
    logic [ADDR_W-1:0] bad_q, bad_d;

    logic [WEN_W-1:0]  lane_wen_c;
    logic [DATA_W-1:0] lane_wdata_c;
    logic              lane_misalign_c;

    store_lane_pack u_lane (
        .size       (req_size),
        .addr_lo    (req_addr[1:0]),
        .data       (req_wdata),
        .wen_c      (lane_wen_c),
        .wdata_c    (lane_wdata_c),
        .misalign_c (lane_misalign_c)
    );

    // Next-state and next-output logic; payload is zero whenever not BUSY
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pkt_d   = '0;
        en_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        ades_d  = 1'b0;
        bad_d   = bad_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (lane_misalign_c) begin
                        state_d = RESP;
                        ades_d  = 1'b1;
                        bad_d   = req_addr;
                    end else begin
                        state_d    = BUSY;
                        en_d       = 1'b1;
                        cnt_d      = '0;
                        pkt_d.addr  = {req_addr[ADDR_W-1:2], 2'b00};
                        pkt_d.wdata = lane_wdata_c;
                        pkt_d.wen   = lane_wen_c;
                    end
                end
            end
            BUSY: begin
                // Ack wins over a timeout landing in the same cycle
                if (mem_ack) begin
                    state_d = RESP;
                    done_d  = 1'b1;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST))) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    en_d  = 1'b1;
                    pkt_d = pkt_q;
                    if (TIMEOUT != 0) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pkt_q   <= '0;
            en_q    <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ades_q  <= 1'b0;
            bad_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pkt_q   <= pkt_d;
            en_q    <= en_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ades_q  <= ades_d;
            bad_q   <= bad_d;
        end
    end

    assign req_ready = ready_q;
    assign mem_en    = en_q;
    assign mem_wen   = pkt_q.wen;
    assign mem_addr  = pkt_q.addr;
    assign mem_wdata = pkt_q.wdata;
    assign done      = done_q;
    assign bus_err   = err_q;
    assign exc_ades  = ades_q;
    assign bad_vaddr = bad_q;

endmodule

// File: tb/tb_mem_store_pack.sv
// Directed bench for mem_store_pack; inputs driven and outputs sampled on the falling edge.
module tb_mem_store_pack;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        done;
    logic        bus_err;
    logic        exc_ades;
    logic [31:0] bad_vaddr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_store_pack #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_size  (req_size),
        .mem_en    (mem_en),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .done      (done),
        .bus_err   (bus_err),
        .exc_ades  (exc_ades),
        .bad_vaddr (bad_vaddr)
    );

    task automatic test_reset;
        resetn = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_size = 2'b00; mem_ack = 1'b0;
        #12;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready act=%b exp=1", req_ready); end
        checks++; if ({mem_en, mem_wen, mem_addr, mem_wdata} !== 69'd0) begin errors++; $display("FAIL reset_mem act=%b/%h/%h/%h exp=0", mem_en, mem_wen, mem_addr, mem_wdata); end
        checks++; if ({done, bus_err, exc_ades, bad_vaddr} !== 35'd0) begin errors++; $display("FAIL reset_flags act=%b%b%b/%h exp=0", done, bus_err, exc_ades, bad_vaddr); end
        @(negedge clk); resetn = 1'b1;
        // ack outside BUSY must not produce anything
        mem_ack = 1'b1;
        @(negedge clk); mem_ack = 1'b0;
        @(negedge clk);
        checks++; if ({done, mem_en, req_ready} !== 3'b001) begin errors++; $display("FAIL idle_ack act=%b exp=001", {done, mem_en, req_ready}); end
    endtask

    task automatic test_sb;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL sb_ready act=%b exp=1", req_ready); end
        req_valid = 1'b1; req_addr = 32'h0000_1003; req_wdata = 32'hAABB_CC5A; req_size = 2'b00;
        @(negedge clk); req_valid = 1'b0;
        checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL sb_en act=%b exp=1", mem_en); end
        checks++; if (mem_wen !== 4'b1000) begin errors++; $display("FAIL sb_wen act=%b exp=1000", mem_wen); end
        checks++; if (mem_wdata !== 32'h5A5A_5A5A) begin errors++; $display("FAIL sb_wdata act=%h exp=5a5a5a5a", mem_wdata); end
        checks++; if (mem_addr !== 32'h0000_1000) begin errors++; $display("FAIL sb_addr act=%h exp=00001000", mem_addr); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL sb_busy_ready act=%b exp=0", req_ready); end
        mem_ack = 1'b1;
        @(negedge clk); mem_ack = 1'b0;
        checks++; if ({done, mem_en, mem_wen} !== 6'b100000) begin errors++; $display("FAIL sb_done act=%b exp=100000", {done, mem_en, mem_wen}); end
        @(negedge clk);
        checks++; if ({done, req_ready} !== 2'b01) begin errors++; $display("FAIL sb_after act=%b exp=01", {done, req_ready}); end
    endtask

    task automatic test_sh_wait;
        int ndone = 0;
        int bad = 0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_2002; req_wdata = 32'h1234_BEEF; req_size = 2'b01;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); req_valid = 1'b0;
            if (mem_en !== 1'b1 || mem_wen !== 4'b1100 || mem_wdata !== 32'hBEEF_BEEF ||
                mem_addr !== 32'h0000_2000 || req_ready !== 1'b0 || done !== 1'b0) bad++;
            if (k == 3) mem_ack = 1'b1;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL sh_stable act=%0d bad cycles exp=0", bad); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); mem_ack = 1'b0;
            if (done === 1'b1) ndone++;
        end
        checks++; if (ndone !== 1) begin errors++; $display("FAIL sh_done_count act=%0d exp=1", ndone); end
    endtask

    task automatic test_timeout;
        int nen = 0;
        int nerr = 0;
        int ndone = 0;
        int err_at = -1;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_3000; req_wdata = 32'hCAFE_F00D; req_size = 2'b10;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); req_valid = 1'b0;
            if (mem_en === 1'b1) nen++;
            if (bus_err === 1'b1) begin nerr++; err_at = k; end
            if (done === 1'b1) ndone++;
        end
        checks++; if (nen !== 16) begin errors++; $display("FAIL to_en_cycles act=%0d exp=16", nen); end
        checks++; if (nerr !== 1 || err_at !== 16) begin errors++; $display("FAIL to_bus_err act=%0d at %0d exp=1 at 16", nerr, err_at); end
        checks++; if (ndone !== 0) begin errors++; $display("FAIL to_no_done act=%0d exp=0", ndone); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL to_ready act=%b exp=1", req_ready); end
    endtask

    task automatic test_ack_at_limit;
        int nerr = 0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_3000; req_wdata = 32'hCAFE_F00D; req_size = 2'b10;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk); req_valid = 1'b0;
            if (k == 15) mem_ack = 1'b1;
        end
        @(negedge clk); mem_ack = 1'b0;
        checks++; if ({done, bus_err} !== 2'b10) begin errors++; $display("FAIL limit_ack act=%b exp=10", {done, bus_err}); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus_err === 1'b1 || done === 1'b1) nerr++;
        end
        checks++; if (nerr !== 0) begin errors++; $display("FAIL limit_quiet act=%0d exp=0", nerr); end
    endtask

    task automatic test_misalign;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_4002; req_wdata = 32'h0102_0304; req_size = 2'b10;
        @(negedge clk); req_valid = 1'b0;
`ifdef STORE_ADES_EXC_EN
        checks++; if ({exc_ades, done, mem_en} !== 3'b100) begin errors++; $display("FAIL ades_pulse act=%b exp=100", {exc_ades, done, mem_en}); end
        checks++; if (bad_vaddr !== 32'h0000_4002) begin errors++; $display("FAIL ades_vaddr act=%h exp=00004002", bad_vaddr); end
        @(negedge clk);
        checks++; if ({exc_ades, mem_en, req_ready} !== 3'b001) begin errors++; $display("FAIL ades_after act=%b exp=001", {exc_ades, mem_en, req_ready}); end
        checks++; if (bad_vaddr !== 32'h0000_4002) begin errors++; $display("FAIL ades_hold act=%h exp=00004002", bad_vaddr); end
`else
        checks++; if ({mem_en, mem_wen} !== 5'b11111) begin errors++; $display("FAIL mis_wen act=%b exp=11111", {mem_en, mem_wen}); end
        checks++; if (mem_addr !== 32'h0000_4000 || mem_wdata !== 32'h0102_0304) begin errors++; $display("FAIL mis_addr act=%h/%h exp=00004000/01020304", mem_addr, mem_wdata); end
        mem_ack = 1'b1;
        @(negedge clk); mem_ack = 1'b0;
        checks++; if ({done, exc_ades, bad_vaddr} !== 34'h2_0000_0000) begin errors++; $display("FAIL mis_done act=%b%b/%h exp=10/0", done, exc_ades, bad_vaddr); end
        @(negedge clk);
        // reserved size behaves as a word store
        req_valid = 1'b1; req_addr = 32'h0000_4001; req_wdata = 32'h5566_7788; req_size = 2'b11;
        @(negedge clk); req_valid = 1'b0;
        checks++; if ({mem_en, mem_wen, mem_addr, mem_wdata} !== {1'b1, 4'b1111, 32'h0000_4000, 32'h5566_7788}) begin errors++; $display("FAIL rsv_word act=%b/%b/%h/%h exp=1/1111/00004000/55667788", mem_en, mem_wen, mem_addr, mem_wdata); end
        mem_ack = 1'b1;
        @(negedge clk); mem_ack = 1'b0;
        @(negedge clk);
`endif
    endtask

    task automatic test_reset_mid_busy;
        int bad = 0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_5004; req_wdata = 32'h9999_AAAA; req_size = 2'b10;
        @(negedge clk); req_valid = 1'b0;
        checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL rst_pre_en act=%b exp=1", mem_en); end
        #2 resetn = 1'b0;
        #1;
        checks++; if ({mem_en, mem_wen, mem_addr} !== 37'd0) begin errors++; $display("FAIL rst_async act=%b/%b/%h exp=0", mem_en, mem_wen, mem_addr); end
        @(negedge clk); resetn = 1'b1;
        mem_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); mem_ack = 1'b0;
            if (done !== 1'b0 || mem_en !== 1'b0 || req_ready !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rst_release act=%0d bad cycles exp=0", bad); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] ea [3];
        logic [31:0] ed [3];
        logic [3:0]  ew [3];
        logic [31:0] ia [3];
        logic [31:0] id [3];
        logic [1:0]  is [3];
        int bad = 0;
        int ndone = 0;
        int idx = 0;
        ia[0] = 32'h0000_6000; id[0] = 32'h1111_2222; is[0] = 2'b10;
        ia[1] = 32'h0000_6101; id[1] = 32'h0000_00C3; is[1] = 2'b00;
        ia[2] = 32'h0000_6202; id[2] = 32'hFFFF_8001; is[2] = 2'b01;
        ea[0] = 32'h0000_6000; ed[0] = 32'h1111_2222; ew[0] = 4'b1111;
        ea[1] = 32'h0000_6100; ed[1] = 32'hC3C3_C3C3; ew[1] = 4'b0010;
        ea[2] = 32'h0000_6200; ed[2] = 32'h8001_8001; ew[2] = 4'b1100;
        @(negedge clk);
        req_valid = 1'b1; req_addr = ia[0]; req_wdata = id[0]; req_size = is[0];
        for (int t = 0; t < 10; t++) begin
            if (t > 0) @(negedge clk);
            if (req_ready !== (t % 3 == 0)) bad++;
            if (mem_en !== (t % 3 == 1)) bad++;
            if (done !== (t % 3 == 2)) bad++;
            if (done === 1'b1) ndone++;
            mem_ack = 1'b0;
            if (t % 3 == 1) begin
                idx = t / 3;
                if (mem_addr !== ea[idx] || mem_wdata !== ed[idx] || mem_wen !== ew[idx]) begin
                    errors++;
                    $display("FAIL b2b_store%0d act=%h/%h/%b exp=%h/%h/%b", idx, mem_addr, mem_wdata, mem_wen, ea[idx], ed[idx], ew[idx]);
                end
                checks++;
                mem_ack = 1'b1;
                if (idx < 2) begin
                    req_addr = ia[idx+1]; req_wdata = id[idx+1]; req_size = is[idx+1];
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_handshake act=%0d bad exp=0", bad); end
        checks++; if (ndone !== 3) begin errors++; $display("FAIL b2b_done_count act=%0d exp=3", ndone); end
    endtask

    initial begin
        test_reset();
        test_sb();
        test_sh_wait();
        test_timeout();
        test_ack_at_limit();
        test_misalign();
        test_reset_mid_busy();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

endmodule
